seq_pattern_driver: RTL and testbench

- Stimulus transmitter and response checker for the 6-input, 1-output registered sequence-pattern cell (inputs CLR, IN_1, IN_3, IN_5, IN_6, IN_8; output v12).
- Drives one input vector per clock from an exhaustive counter or a 6-bit LFSR.
- Carries an internal golden model of the cell through a latency-matched pipeline and compares it against the returned v12 each cycle.
- Sits next to the pattern cell in the self-test harness and reports pass/fail, error count and first failing vector.

---
 rtl/seq_pattern_driver.sv | 169 ++++++++++++++++
 tb/tb_seq_pattern_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_driver.sv
// rtl/seq_pattern_driver.sv - stimulus driver and golden-model response checker for the v12 pattern cell
module seq_pattern_driver #(
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned CNT_W     = 16,
    parameter logic [5:0]  LFSR_SEED = 6'h01
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] num_vectors,
    output logic             stim_clr,
    output logic             stim_in1,
    output logic             stim_in3,
    output logic             stim_in5,
    output logic             stim_in6,
    output logic             stim_in8,
    input  logic             rsp_v12,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam logic [5:0] SEED = (LFSR_SEED == 6'h00) ? 6'h01 : LFSR_SEED;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_next;
    logic             mode_r;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] vec_idx;
    logic [5:0]       cnt;
    logic [5:0]       lfsr;
    logic [3:0]       drain_cnt;
    logic [5:0]       stim_vec;
    logic             done_r, done_next;
    logic             pass_r;
    logic [CNT_W-1:0] err_r, err_next;
    logic [CNT_W-1:0] first_r;

    logic             pipe_v   [LATENCY];
    logic             pipe_exp [LATENCY];
    logic [CNT_W-1:0] pipe_idx [LATENCY];

    logic [5:0]       gen_vec;
    logic             start_ok;
    logic             push;
    logic             mismatch;

    // vec[5]=CLR, vec[4]=IN_1, vec[3]=IN_3, vec[2]=IN_5, vec[1]=IN_6, vec[0]=IN_8
    function automatic logic golden(input logic [5:0] v);
        return v[5] & ~(v[2] & v[3] & ~v[4] & ~(v[1] & ~v[0]));
    endfunction

    always_comb begin
        gen_vec   = mode_r ? lfsr : cnt;
        start_ok  = start && (state == IDLE || state == DONE);
        push      = (state == RUN);
        mismatch  = pipe_v[LATENCY-1] && (pipe_exp[LATENCY-1] != rsp_v12);
        err_next  = err_r;
        if (mismatch && err_r != {CNT_W{1'b1}})
            err_next = err_r + 1'b1;
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (num_vectors == '0) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (remaining == CNT_W'(1))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == 4'(LATENCY - 1)) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            state     <= IDLE;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            err_r     <= '0;
            first_r   <= '1;
            stim_vec  <= '0;
            lfsr      <= SEED;
            cnt       <= '0;
            mode_r    <= 1'b0;
            remaining <= '0;
            vec_idx   <= '0;
            drain_cnt <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_exp[i] <= 1'b0;
                pipe_idx[i] <= '0;
            end
        end else begin
            state  <= state_next;
            done_r <= done_next;

            // Tail of this shift line lines up with the cell's response.
            pipe_v[0]   <= push;
            pipe_exp[0] <= golden(gen_vec);
            pipe_idx[0] <= vec_idx;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_exp[i] <= pipe_exp[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end

            if (start_ok) begin
                mode_r    <= mode;
                remaining <= num_vectors;
                vec_idx   <= '0;
                cnt       <= '0;
                lfsr      <= SEED;
                err_r     <= '0;
                first_r   <= '1;
                drain_cnt <= '0;
                pass_r    <= (num_vectors == '0);
            end else begin
                err_r <= err_next;
                if (mismatch && first_r == {CNT_W{1'b1}})
                    first_r <= pipe_idx[LATENCY-1];
                if (push) begin
                    stim_vec  <= gen_vec;
                    remaining <= remaining - 1'b1;
                    vec_idx   <= vec_idx + 1'b1;
                    cnt       <= cnt + 1'b1;
                    lfsr      <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
                end
                if (state == DRAIN)
                    drain_cnt <= drain_cnt + 1'b1;
                if (done_next)
                    pass_r <= (err_next == '0);
            end
        end
    end

    assign stim_clr      = stim_vec[5];
    assign stim_in1      = stim_vec[4];
    assign stim_in3      = stim_vec[3];
    assign stim_in5      = stim_vec[2];
    assign stim_in6      = stim_vec[1];
    assign stim_in8      = stim_vec[0];
    assign busy          = (state == RUN) || (state == DRAIN);
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_r;
    assign first_err_idx = first_r;

endmodule

// File: tb/tb_seq_pattern_driver.sv
// tb/tb_seq_pattern_driver.sv - scoreboard bench for seq_pattern_driver at LATENCY 1 and 3
module tb_seq_pattern_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        pass;
        logic [15:0] err;
        logic [15:0] first;
    } res_t;

    res_t q1[$];
    res_t q3[$];

    logic        rst1, start1, mode1, rsp1, busy1, done1, pass1;
    logic [15:0] num1, err1, first1;
    logic        c1, a1, b1, e1, f1, g1;
    logic        rst3, start3, mode3, rsp3, busy3, done3, pass3;
    logic [15:0] num3, err3, first3;
    logic        c3, a3, b3, e3, f3, g3;
    logic [5:0]  vec1, vec3, d1, d2;
    int          fault1;
    logic        sel3;

    seq_pattern_driver #(.LATENCY(1), .CNT_W(16), .LFSR_SEED(6'h01)) dut1 (
        .blif_clk_net(clk), .blif_reset_net(rst1), .start(start1), .mode(mode1),
        .num_vectors(num1), .stim_clr(c1), .stim_in1(a1), .stim_in3(b1),
        .stim_in5(e1), .stim_in6(f1), .stim_in8(g1), .rsp_v12(rsp1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_idx(first1)
    );

    seq_pattern_driver #(.LATENCY(3), .CNT_W(16), .LFSR_SEED(6'h01)) dut3 (
        .blif_clk_net(clk), .blif_reset_net(rst3), .start(start3), .mode(mode3),
        .num_vectors(num3), .stim_clr(c3), .stim_in1(a3), .stim_in3(b3),
        .stim_in5(e3), .stim_in6(f3), .stim_in8(g3), .rsp_v12(rsp3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_err_idx(first3)
    );

    assign vec1 = {c1, a1, b1, e1, f1, g1};
    assign vec3 = {c3, a3, b3, e3, f3, g3};

    function automatic logic cell_f(input logic [5:0] v);
        logic clr, in1, in3, in5, in6, in8;
        {clr, in1, in3, in5, in6, in8} = v;
        return clr && !(in5 && in3 && !in1 && (!in6 || in8));
    endfunction

    always_comb begin
        rsp1 = cell_f(vec1);
        if (fault1 == 1) rsp1 = 1'b0;
        if (fault1 == 2) rsp1 = 1'b1;
    end

    always_ff @(posedge clk) begin
        d1 <= vec3;
        d2 <= d1;
    end
    assign rsp3 = sel3 ? cell_f(d2) : cell_f(d1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        res_t r;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected_done actual=1 required=0");
            end else begin
                r = q1.pop_front();
                check("dut1_pass", 32'(pass1), 32'(r.pass));
                check("dut1_err_count", 32'(err1), 32'(r.err));
                check("dut1_first_err_idx", 32'(first1), 32'(r.first));
            end
        end
        if (done3 === 1'b1) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut3_unexpected_done actual=1 required=0");
            end else begin
                r = q3.pop_front();
                check("dut3_pass", 32'(pass3), 32'(r.pass));
                check("dut3_err_count", 32'(err3), 32'(r.err));
                check("dut3_first_err_idx", 32'(first3), 32'(r.first));
            end
        end
    end

    task automatic pulse1(input logic m, input logic [15:0] n);
        @(negedge clk);
        start1 = 1'b1; mode1 = m; num1 = n;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic go1(input logic m, input logic [15:0] n, input logic ep,
                       input logic [15:0] ee, input logic [15:0] ef);
        q1.push_back('{ep, ee, ef});
        pulse1(m, n);
    endtask

    task automatic go3(input logic m, input logic [15:0] n, input logic ep,
                       input logic [15:0] ee, input logic [15:0] ef);
        q3.push_back('{ep, ee, ef});
        @(negedge clk);
        start3 = 1'b1; mode3 = m; num3 = n;
        @(negedge clk);
        start3 = 1'b0;
    endtask

    task automatic wait_done1(input int budget);
        for (int k = 0; k < budget && done1 !== 1'b1; k++) @(negedge clk);
        check("dut1_done_seen", 32'(done1), 32'd1);
    endtask

    task automatic wait_done3(input int budget);
        for (int k = 0; k < budget && done3 !== 1'b1; k++) @(negedge clk);
        check("dut3_done_seen", 32'(done3), 32'd1);
    endtask

    initial begin
        logic [5:0] lfsr_tab [8];
        logic [5:0] v;
        lfsr_tab = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21, 6'h03, 6'h06};
        rst1 = 1'b1; start1 = 1'b0; mode1 = 1'b0; num1 = '0; fault1 = 0;
        rst3 = 1'b1; start3 = 1'b0; mode3 = 1'b0; num3 = '0; sel3 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_pass", 32'(pass1), 32'd0);
        check("rst_err", 32'(err1), 32'd0);
        check("rst_first", 32'(first1), 32'hFFFF);
        check("rst_stim", 32'(vec1), 32'd0);
        check("rst3_busy", 32'(busy3), 32'd0);
        check("rst3_first", 32'(first3), 32'hFFFF);
        rst1 = 1'b0; rst3 = 1'b0;

        // Exhaustive counter, correct cell; first vectors count up from 0.
        fault1 = 0;
        go1(1'b0, 16'd64, 1'b1, 16'd0, 16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("cnt_stim", 32'(vec1), 32'(i));
        end
        wait_done1(200);

        // Stuck-at-0 with a start pulse mid-run that must be ignored.
        fault1 = 1;
        go1(1'b0, 16'd64, 1'b0, 16'd29, 16'd32);
        repeat (20) @(negedge clk);
        start1 = 1'b1; mode1 = 1'b1; num1 = 16'd5;
        @(negedge clk);
        start1 = 1'b0;
        check("midrun_busy", 32'(busy1), 32'd1);
        wait_done1(200);

        fault1 = 2;
        go1(1'b0, 16'd64, 1'b0, 16'd35, 16'd0);
        wait_done1(200);

        // Zero-length run after a failing one: done next cycle, pass set.
        fault1 = 0;
        go1(1'b0, 16'd0, 1'b1, 16'd0, 16'hFFFF);
        check("zero_done_next", 32'(done1), 32'd1);
        wait_done1(4);

        // LFSR mode over two full periods.
        go1(1'b1, 16'd126, 1'b1, 16'd0, 16'hFFFF);
        v = 6'h01;
        for (int i = 0; i < 126; i++) begin
            @(negedge clk);
            if (i < 8) check("lfsr_tab", 32'(vec1), 32'(lfsr_tab[i]));
            check("lfsr_seq", 32'(vec1), 32'(v));
            check("lfsr_nonzero", 32'(vec1 != 6'h00), 32'd1);
            v = {v[4:0], v[5] ^ v[4]};
        end
        wait_done1(20);

        // Latency 3: matched delay passes, one-cycle-short delay fails.
        sel3 = 1'b1;
        go3(1'b0, 16'd64, 1'b1, 16'd0, 16'hFFFF);
        wait_done3(200);
        sel3 = 1'b0;
        go3(1'b0, 16'd64, 1'b0, 16'd5, 16'd31);
        wait_done3(200);

        // Reset at vector 10 of a stuck-at-1 run.
        fault1 = 2;
        pulse1(1'b0, 16'd64);
        repeat (10) @(negedge clk);
        check("pre_reset_err", 32'(err1), 32'd9);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        check("post_reset_busy", 32'(busy1), 32'd0);
        check("post_reset_err", 32'(err1), 32'd0);
        check("post_reset_first", 32'(first1), 32'hFFFF);
        check("post_reset_stim", 32'(vec1), 32'd0);
        check("post_reset_pass", 32'(pass1), 32'd0);
        repeat (8) @(negedge clk);
        fault1 = 0;
        go1(1'b0, 16'd64, 1'b1, 16'd0, 16'hFFFF);
        wait_done1(200);

        repeat (3) @(negedge clk);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q3_drained", 32'(q3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
